// File: rtl/tinytpu_mm_serial.sv
// tinytpu_mm_serial: serial-load N x N matrix-multiply core (Z = X*Y or Z += X*Y).
// Operands arrive LANES bits per beat, row-major, LSB lanes first; the result
// leaves the same way with tx_ready marking each valid beat.
// Optional build macro: TINYTPU_SIGNED_EN selects two's-complement operands
// (sign-extended products); when undefined, operands are unsigned.
module tinytpu_mm_serial #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int LANES = 1,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] data_in_x,
    input  logic [LANES-1:0] data_in_y,
    input  logic             load_en,
    input  logic             init,
    output logic [LANES-1:0] data_out_z,
    output logic             tx_ready,
    output logic             busy
);

    localparam int BPE   = D_W / LANES;
    localparam int L     = N * N * BPE;
    localparam int S     = N * N * ACC_W / LANES;
    localparam int LD_W  = $clog2(L);
    localparam int SH_W  = $clog2(S);
    localparam int IX_W  = $clog2(N);
    localparam int XW    = N * N * D_W;
    localparam int AW    = N * N * ACC_W;
    localparam int XI_W  = $clog2(XW);
    localparam int AI_W  = $clog2(AW);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_SHIFT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [SH_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [IX_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    // Operand and accumulator files are flat row-major vectors, element 0 in
    // the low bits, so a serial beat index maps directly to a bit offset.
    logic [XW-1:0]     x_q, x_d, y_q, y_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [LANES-1:0]  data_out_z_q, data_out_z_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;

    logic [XI_W-1:0]   ld_base_s, x_base_s, y_base_s;
    logic [AI_W-1:0]   acc_base_s, z_base_s;
    logic [D_W-1:0]    x_el_s, y_el_s;
    logic [2*D_W-1:0]  prod_s;
    logic [ACC_W-1:0]  prod_ext_s;

    // MAC datapath: operand selection for the current (i, j, k) and product extension.
    always_comb begin
        ld_base_s  = XI_W'(int'(load_cnt_q) * LANES);
        x_base_s   = XI_W'((int'(i_q) * N + int'(k_q)) * D_W);
        y_base_s   = XI_W'((int'(k_q) * N + int'(j_q)) * D_W);
        acc_base_s = AI_W'((int'(i_q) * N + int'(j_q)) * ACC_W);
        x_el_s     = x_q[x_base_s +: D_W];
        y_el_s     = y_q[y_base_s +: D_W];
`ifdef TINYTPU_SIGNED_EN
        prod_s     = $signed(x_el_s) * $signed(y_el_s);
        prod_ext_s = ACC_W'($signed(prod_s));
`else
        prod_s     = x_el_s * y_el_s;
        prod_ext_s = ACC_W'(prod_s);
`endif
    end

    // Next-state, counters, register files and registered-output values.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        shift_cnt_d = shift_cnt_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q;
                end
                // Beat 0 is captured in IDLE itself; load_cnt_q is 0 here.
                if (load_en) begin
                    x_d[ld_base_s +: LANES] = data_in_x;
                    y_d[ld_base_s +: LANES] = data_in_y;
                    load_cnt_d              = LD_W'(1);
                    state_d                 = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_en) begin
                    x_d[ld_base_s +: LANES] = data_in_x;
                    y_d[ld_base_s +: LANES] = data_in_y;
                    if (load_cnt_q == LD_W'(L - 1)) begin
                        load_cnt_d = '0;
                        i_d        = '0;
                        j_d        = '0;
                        k_d        = '0;
                        state_d    = ST_COMPUTE;
                    end else begin
                        load_cnt_d = load_cnt_q + LD_W'(1);
                    end
                end else begin
                    load_cnt_d = load_cnt_q;
                end
            end
            ST_COMPUTE: begin
                acc_d[acc_base_s +: ACC_W] = acc_q[acc_base_s +: ACC_W] + prod_ext_s;
                if (k_q == IX_W'(N - 1)) begin
                    k_d = '0;
                    if (j_q == IX_W'(N - 1)) begin
                        j_d = '0;
                        if (i_q == IX_W'(N - 1)) begin
                            i_d         = '0;
                            shift_cnt_d = '0;
                            state_d     = ST_SHIFT;
                        end else begin
                            i_d = i_q + IX_W'(1);
                        end
                    end else begin
                        j_d = j_q + IX_W'(1);
                    end
                end else begin
                    k_d = k_q + IX_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SH_W'(S - 1)) begin
                    shift_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state; the
        // first shift beat uses acc_d so it already includes the final MAC.
        z_base_s   = AI_W'(int'(shift_cnt_d) * LANES);
        tx_ready_d = (state_d == ST_SHIFT);
        busy_d     = (state_d == ST_COMPUTE) || (state_d == ST_SHIFT);
        if (state_d == ST_SHIFT) begin
            data_out_z_d = acc_d[z_base_s +: LANES];
        end else begin
            data_out_z_d = '0;
        end
    end

    // State, file and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            load_cnt_q   <= '0;
            shift_cnt_q  <= '0;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            acc_q        <= '0;
            data_out_z_q <= '0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            shift_cnt_q  <= shift_cnt_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_q        <= acc_d;
            data_out_z_q <= data_out_z_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out_z = data_out_z_q;
    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tinytpu_mm_serial.sv
// Self-checking bench for tinytpu_mm_serial: a LANES=1 and a LANES=2 instance,
// a reference model of the accumulators, and a queue of expected output beats.
module tb_tinytpu_mm_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       x1, y1, le1, in1, z1, tx1, b1;
    logic [1:0] x2, y2, z2;
    logic       le2, in2, tx2, b2;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    int         acc_m[2][4];

    always #5 clk = ~clk;

    tinytpu_mm_serial #(.D_W(8), .N(2), .LANES(1), .ACC_W(20)) u_dut1 (
        .clk(clk), .rst(rst), .data_in_x(x1), .data_in_y(y1), .load_en(le1),
        .init(in1), .data_out_z(z1), .tx_ready(tx1), .busy(b1)
    );

    tinytpu_mm_serial #(.D_W(8), .N(2), .LANES(2), .ACC_W(20)) u_dut2 (
        .clk(clk), .rst(rst), .data_in_x(x2), .data_in_y(y2), .load_en(le2),
        .init(in2), .data_out_z(z2), .tx_ready(tx2), .busy(b2)
    );

    function automatic int elem_val(input logic [7:0] v);
`ifdef TINYTPU_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    function automatic logic obs_tx(input int sel);
        return (sel != 0) ? tx2 : tx1;
    endfunction

    function automatic logic obs_busy(input int sel);
        return (sel != 0) ? b2 : b1;
    endfunction

    function automatic logic [1:0] obs_z(input int sel);
        return (sel != 0) ? z2 : {1'b0, z1};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic le, input logic ini,
                          input logic [1:0] xb, input logic [1:0] yb);
        if (sel != 0) begin
            le2 = le; in2 = ini; x2 = xb; y2 = yb;
        end else begin
            le1 = le; in1 = ini; x1 = xb[0]; y1 = yb[0];
        end
    endtask

    // init_mode: 0 none, 1 separate pulse before load, 2 together with beat 0.
    // rst_at >= 0 asserts rst while that shift beat is presented.
    task automatic run_case(input string name, input int sel, input int init_mode,
                            input logic [31:0] xv, input logic [31:0] yv,
                            input bit gaps, input bit disturb, input int rst_at);
        int          nb, sb, cyc, s;
        logic [79:0] zv;
        logic [1:0]  xb, yb, got, expb;
        nb = (sel != 0) ? 16 : 32;
        sb = (sel != 0) ? 40 : 80;
        if (init_mode != 0) begin
            for (int e = 0; e < 4; e++) acc_m[sel][e] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = acc_m[sel][i*2+j];
                for (int k = 0; k < 2; k++) begin
                    s = s + elem_val(xv[8*(i*2+k) +: 8]) * elem_val(yv[8*(k*2+j) +: 8]);
                end
                acc_m[sel][i*2+j] = s & 32'h000F_FFFF;
            end
        end
        for (int e = 0; e < 4; e++) zv[20*e +: 20] = 20'(acc_m[sel][e]);
        for (int b = 0; b < sb; b++) begin
            if (sel != 0) exp_q.push_back(zv[2*b +: 2]);
            else          exp_q.push_back({1'b0, zv[b]});
        end

        if (init_mode == 1) begin
            set_in(sel, 1'b0, 1'b1, 2'b00, 2'b00);
            step;
        end
        for (int b = 0; b < nb; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    set_in(sel, 1'b0, 1'b0, 2'($urandom), 2'($urandom));
                    step;
                end
            end
            if (sel != 0) begin
                xb = xv[2*b +: 2]; yb = yv[2*b +: 2];
            end else begin
                xb = {1'b0, xv[b]}; yb = {1'b0, yv[b]};
            end
            set_in(sel, 1'b1, (b == 0) && (init_mode == 2), xb, yb);
            step;
        end
        set_in(sel, 1'b0, 1'b0, 2'b00, 2'b00);

        checks++;
        if (obs_busy(sel) !== 1'b1 || obs_tx(sel) !== 1'b0)
            $display("FAIL %s compute_entry: busy=%b tx_ready=%b, required busy=1 tx_ready=0",
                     name, obs_busy(sel), obs_tx(sel));
        if (obs_busy(sel) !== 1'b1 || obs_tx(sel) !== 1'b0) errors++;

        cyc = 1;
        if (disturb) begin
            set_in(sel, 1'b1, 1'b1, 2'b11, 2'b11);
            step; step; step;
            set_in(sel, 1'b0, 1'b0, 2'b00, 2'b00);
            cyc = 4;
        end
        while (obs_tx(sel) !== 1'b1 && cyc < 100) begin
            step;
            cyc++;
        end
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL %s first_tx_latency: %0d cycles after last beat, required 9", name, cyc);
        end
        if (cyc >= 100) begin
            exp_q.delete();
            return;
        end

        for (int b = 0; b < sb; b++) begin
            got  = obs_z(sel);
            expb = exp_q.pop_front();
            checks++;
            if (obs_tx(sel) !== 1'b1 || obs_busy(sel) !== 1'b1 || got !== expb) begin
                errors++;
                $display("FAIL %s beat%0d: z=%b tx_ready=%b busy=%b, required z=%b tx_ready=1 busy=1",
                         name, b, got, obs_tx(sel), obs_busy(sel), expb);
            end
            if (b == rst_at) begin
                rst = 1'b1;
                step;
                rst = 1'b0;
                checks++;
                if (tx1 !== 1'b0 || b1 !== 1'b0 || z1 !== 1'b0 || tx2 !== 1'b0 || b2 !== 1'b0 || z2 !== 2'b00) begin
                    errors++;
                    $display("FAIL %s rst_mid_shift: tx=%b/%b busy=%b/%b z=%b/%b, required all 0",
                             name, tx1, tx2, b1, b2, z1, z2);
                end
                for (int e = 0; e < 4; e++) begin
                    acc_m[0][e] = 0;
                    acc_m[1][e] = 0;
                end
                exp_q.delete();
                return;
            end
            step;
        end
        checks++;
        if (obs_tx(sel) !== 1'b0 || obs_busy(sel) !== 1'b0 || obs_z(sel) !== 2'b00) begin
            errors++;
            $display("FAIL %s end_of_shift: tx_ready=%b busy=%b z=%b, required 0 0 00",
                     name, obs_tx(sel), obs_busy(sel), obs_z(sel));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 2'b00, 2'b00);
        set_in(1, 1'b0, 1'b0, 2'b00, 2'b00);
        step; step;
        checks++;
        if (tx1 !== 1'b0 || b1 !== 1'b0 || z1 !== 1'b0 || tx2 !== 1'b0 || b2 !== 1'b0 || z2 !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: tx=%b/%b busy=%b/%b z=%b/%b, required all 0",
                     tx1, tx2, b1, b2, z1, z2);
        end
        rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            acc_m[0][e] = 0;
            acc_m[1][e] = 0;
        end
        step;
    endtask

    task automatic test_basic;
        run_case("basic", 0, 1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, -1);
    endtask

    task automatic test_accumulate;
        run_case("accumulate", 0, 0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reinit;
        run_case("reinit", 0, 1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, -1);
    endtask

    task automatic test_sign_bits;
        run_case("sign_bits", 0, 1, {8'hFF, 8'h00, 8'h00, 8'hFF}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, -1);
    endtask

    task automatic test_gaps_disturb;
        run_case("gaps_disturb", 0, 1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1, 1'b1, -1);
    endtask

    task automatic test_rst_mid_shift;
        run_case("rst_mid_shift", 0, 0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, 40);
        run_case("after_rst", 0, 2, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        run_case("back_to_back", 0, 2, {8'd9, 8'd200, 8'd17, 8'd130}, {8'd250, 8'd3, 8'd77, 8'd11}, 1'b0, 1'b0, -1);
    endtask

    task automatic test_lanes2;
        run_case("lanes2", 1, 1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, -1);
        run_case("lanes2_acc", 1, 0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1, 1'b0, -1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_accumulate;
        test_reinit;
        test_sign_bits;
        test_gaps_disturb;
        test_rst_mid_shift;
        test_back_to_back;
        test_lanes2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
